// File: rtl/ttc_sup_pkg.sv
// Shared state encoding and default constants for the TTC clock supervisor.
// Imported by ttc_clk_supervisor and its testbench.
package ttc_sup_pkg;

  typedef enum logic [1:0] {
    LOST  = 2'd0,
    QUAL  = 2'd1,
    READY = 2'd2
  } ttc_sup_state_e;

  // 2**16 dcsclk cycles = 655.36 us at 100 MHz; 40.079 MHz / 64 toggles -> 410 edges
  localparam int DEF_WIN_W     = 16;
  localparam int DEF_CNT_W     = 12;
  localparam int DEF_EXP_CNT   = 410;
  localparam int DEF_TOL       = 4;
  localparam int DEF_GOOD_WIN  = 4;
  localparam int DEF_STALL_CYC = 1024;

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchroniser for an asynchronous level, with a one-cycle pulse
// on either polarity of change of the synchronised level.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 ^ s3;

endmodule

// File: rtl/ttc_clk_supervisor.sv
// Qualifies the TTC-derived readout clock: counts divided-toggle edges per
// dcsclk window, detects stalls, and drives ttc_ready for the readout clock mux.
module ttc_clk_supervisor
  import ttc_sup_pkg::*;
#(
  parameter int WIN_W     = DEF_WIN_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int EXP_CNT   = DEF_EXP_CNT,
  parameter int TOL       = DEF_TOL,
  parameter int GOOD_WIN  = DEF_GOOD_WIN,
  parameter int STALL_CYC = DEF_STALL_CYC
) (
  input  logic             dcsclk,
  input  logic             reset_n,
  input  logic             ttc_div_tgl,
  input  logic             mon_en,
  input  logic             sticky_clr,
  output logic             ttc_ready,
  output logic             ttc_lost,
  output logic             ttc_lost_sticky,
  output logic [CNT_W-1:0] ttc_freq_cnt,
  output logic             freq_valid,
  output ttc_sup_state_e   state_dbg
);

  localparam int SCNT_W = $clog2(STALL_CYC + 1);
  localparam int QCNT_W = $clog2(GOOD_WIN + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_LO     = CNT_W'(EXP_CNT - TOL);
  localparam logic [CNT_W-1:0]  CNT_HI     = CNT_W'(EXP_CNT + TOL);
  localparam logic [SCNT_W-1:0] SCNT_STALL = SCNT_W'(STALL_CYC);
  localparam logic [QCNT_W-1:0] QCNT_DONE  = QCNT_W'(GOOD_WIN);

  logic              tgl_edge;
  logic [WIN_W-1:0]  wcnt;
  logic [CNT_W-1:0]  ecnt;
  logic [CNT_W-1:0]  meas;
  logic [SCNT_W-1:0] scnt;
  logic [QCNT_W-1:0] qcnt;
  logic [QCNT_W-1:0] qcnt_nxt;
  ttc_sup_state_e    state;
  ttc_sup_state_e    state_nxt;
  logic              we;
  logic              good;
  logic              stall;
  logic              restart;
  logic              lost_evt;

  sync_edge_det u_sync (
    .clk        (dcsclk),
    .rst_n      (reset_n),
    .async_in   (ttc_div_tgl),
    .edge_pulse (tgl_edge)
  );

  // An edge arriving on the window-end cycle still belongs to the closing window.
  assign we    = mon_en && (&wcnt);
  assign meas  = (ecnt == CNT_MAX) ? CNT_MAX : ecnt + CNT_W'(tgl_edge);
  assign good  = (meas >= CNT_LO) && (meas <= CNT_HI);
  assign stall = mon_en && (scnt == SCNT_STALL);

  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    restart   = 1'b0;
    if (!mon_en) begin
      state_nxt = LOST;
      qcnt_nxt  = '0;
    end else begin
      unique case (state)
        LOST: begin
          if (we && good) begin
            if (GOOD_WIN == 1) begin
              state_nxt = READY;
              qcnt_nxt  = '0;
            end else begin
              state_nxt = QUAL;
              qcnt_nxt  = QCNT_W'(1);
            end
          end
        end
        QUAL: begin
          if (stall) begin
            state_nxt = LOST;
            qcnt_nxt  = '0;
            restart   = 1'b1;
          end else if (we) begin
            if (!good) begin
              state_nxt = LOST;
              qcnt_nxt  = '0;
            end else if (qcnt + QCNT_W'(1) == QCNT_DONE) begin
              state_nxt = READY;
              qcnt_nxt  = '0;
            end else begin
              qcnt_nxt = qcnt + QCNT_W'(1);
            end
          end
        end
        READY: begin
          if (stall) begin
            state_nxt = LOST;
            restart   = 1'b1;
          end else if (we && !good) begin
            state_nxt = LOST;
          end
        end
        default: begin
          state_nxt = LOST;
          qcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Disabling supervision forces LOST silently; only a supervised drop reports loss.
  assign lost_evt = mon_en && (state == READY) && (state_nxt == LOST);

  always_ff @(posedge dcsclk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt <= '0;
      ecnt <= '0;
      scnt <= '0;
    end else begin
      if (!mon_en || restart) begin
        wcnt <= '0;
      end else begin
        wcnt <= wcnt + WIN_W'(1);
      end

      if (!mon_en || restart || we) begin
        ecnt <= '0;
      end else if (tgl_edge && (ecnt != CNT_MAX)) begin
        ecnt <= ecnt + CNT_W'(1);
      end

      if (!mon_en || tgl_edge) begin
        scnt <= '0;
      end else if (scnt != SCNT_STALL) begin
        scnt <= scnt + SCNT_W'(1);
      end
    end
  end

  // freq_valid is a one-cycle pulse qualifying a new ttc_freq_cnt value; there
  // is no ready/backpressure, the value simply holds until the next window end.
  always_ff @(posedge dcsclk or negedge reset_n) begin
    if (!reset_n) begin
      ttc_freq_cnt <= '0;
      freq_valid   <= 1'b0;
    end else begin
      freq_valid <= we;
      if (we) begin
        ttc_freq_cnt <= meas;
      end
    end
  end

  always_ff @(posedge dcsclk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= LOST;
      qcnt            <= '0;
      ttc_ready       <= 1'b0;
      ttc_lost        <= 1'b0;
      ttc_lost_sticky <= 1'b0;
    end else begin
      state     <= state_nxt;
      qcnt      <= qcnt_nxt;
      ttc_ready <= (state_nxt == READY);
      ttc_lost  <= lost_evt;
      if (lost_evt) begin
        ttc_lost_sticky <= 1'b1;
      end else if (sticky_clr) begin
        ttc_lost_sticky <= 1'b0;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ttc_clk_supervisor.sv
// Directed bench for ttc_clk_supervisor with a shortened window (1024 cycles)
// so qualification, bounds, stall and disable cases fit in a short run.
module tb_ttc_clk_supervisor;
  import ttc_sup_pkg::*;

  localparam int WIN_W     = 10;
  localparam int CNT_W     = 8;
  localparam int EXP_CNT   = 64;
  localparam int TOL       = 4;
  localparam int GOOD_WIN  = 4;
  localparam int STALL_CYC = 128;
  localparam int WIN       = 1 << WIN_W;

  logic             dcsclk      = 1'b0;
  logic             reset_n     = 1'b0;
  logic             ttc_div_tgl = 1'b0;
  logic             mon_en      = 1'b0;
  logic             sticky_clr  = 1'b0;
  logic             ttc_ready;
  logic             ttc_lost;
  logic             ttc_lost_sticky;
  logic [CNT_W-1:0] ttc_freq_cnt;
  logic             freq_valid;
  ttc_sup_state_e   state_dbg;

  int checks    = 0;
  int errors    = 0;
  int lost_cnt  = 0;
  int since_tgl = 0;
  int lat;

  ttc_clk_supervisor #(
    .WIN_W     (WIN_W),
    .CNT_W     (CNT_W),
    .EXP_CNT   (EXP_CNT),
    .TOL       (TOL),
    .GOOD_WIN  (GOOD_WIN),
    .STALL_CYC (STALL_CYC)
  ) dut (
    .dcsclk          (dcsclk),
    .reset_n         (reset_n),
    .ttc_div_tgl     (ttc_div_tgl),
    .mon_en          (mon_en),
    .sticky_clr      (sticky_clr),
    .ttc_ready       (ttc_ready),
    .ttc_lost        (ttc_lost),
    .ttc_lost_sticky (ttc_lost_sticky),
    .ttc_freq_cnt    (ttc_freq_cnt),
    .freq_valid      (freq_valid),
    .state_dbg       (state_dbg)
  );

  // clock / watchdog
  always #5 dcsclk = ~dcsclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One dcsclk cycle; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge dcsclk);
    #1;
    since_tgl++;
    if (ttc_lost === 1'b1) lost_cnt++;
  endtask

  task automatic toggle();
    ttc_div_tgl = ~ttc_div_tgl;
    since_tgl   = 0;
  endtask

  // Entered in the cycle where the DUT window counter is 0. Toggles at
  // cycles off + k*sp (k < n) land their edge pulse 2 cycles later.
  task automatic run_window(input int n, input int sp, input int off,
                            input bit fast, input int clr_at, input int len);
    for (int c = 0; c < len; c++) begin
      if (fast) begin
        if (c <= WIN - 3) toggle();
      end else if (n > 0 && c >= off && ((c - off) % sp) == 0 && ((c - off) / sp) < n) begin
        toggle();
      end
      sticky_clr = (c == clr_at);
      if (c == WIN / 2) begin
        chk("fv_mid", freq_valid, 0);
        chk("lost_mid", ttc_lost, 0);
      end
      step();
    end
    sticky_clr = 1'b0;
  endtask

  task automatic win(input int n, input int clr_at);
    run_window(n, (n > 0) ? (WIN - 4) / n : 1, 2, 1'b0, clr_at, WIN);
  endtask

  task automatic win_chk(input string tag, input int fcnt, input ttc_sup_state_e st);
    chk({tag, "_fv"}, freq_valid, 1);
    chk({tag, "_fcnt"}, ttc_freq_cnt, fcnt);
    chk({tag, "_state"}, st, st);
    chk({tag, "_dbg"}, state_dbg, st);
    chk({tag, "_ready"}, ttc_ready, (st == READY) ? 1 : 0);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge dcsclk);
    #1;
    chk("rst_ready", ttc_ready, 0);
    chk("rst_lost", ttc_lost, 0);
    chk("rst_sticky", ttc_lost_sticky, 0);
    chk("rst_fcnt", ttc_freq_cnt, 0);
    chk("rst_fv", freq_valid, 0);
    chk("rst_state", state_dbg, LOST);
    mon_en  = 1'b1;
    reset_n = 1'b1;

    // nominal rate: READY after the 4th good window
    win(64, -1); win_chk("t1_w1", 64, QUAL);
    win(64, -1); win_chk("t1_w2", 64, QUAL);
    win(64, -1); win_chk("t1_w3", 64, QUAL);
    win(64, -1); win_chk("t1_w4", 64, READY);
    chk("t1_lost_cnt", lost_cnt, 0);

    // toggle stops in READY -> stall loss
    lat = -1;
    for (int i = 0; i < STALL_CYC + 20; i++) begin
      step();
      if (ttc_lost === 1'b1) begin
        lat = since_tgl;
        break;
      end
    end
    chk("t3_lat_ok", (lat >= STALL_CYC && lat <= STALL_CYC + 4) ? 1 : 0, 1);
    chk("t3_ready", ttc_ready, 0);
    chk("t3_sticky", ttc_lost_sticky, 1);
    chk("t3_fcnt", ttc_freq_cnt, 64);
    chk("t3_state", state_dbg, LOST);
    chk("t3_lost_cnt", lost_cnt, 1);

    // tolerance bounds; sticky cleared early in the first window
    win(60, 5);  win_chk("t2_60", 60, QUAL);
    chk("t2_sticky_clr", ttc_lost_sticky, 0);
    win(68, -1); win_chk("t2_68", 68, QUAL);
    win(59, -1); win_chk("t2_59", 59, LOST);
    win(60, -1); win_chk("t2_60b", 60, QUAL);
    win(69, -1); win_chk("t2_69", 69, LOST);
    win(60, -1); win_chk("t2_q1", 60, QUAL);
    win(68, -1); win_chk("t2_q2", 68, QUAL);
    win(64, -1); win_chk("t2_q3", 64, QUAL);
    win(60, -1); win_chk("t2_q4", 60, READY);
    chk("t2_lost_cnt", lost_cnt, 1);

    // stall lands exactly on the window-end cycle, sticky_clr on the same cycle
    run_window(64, 14, 10, 1'b0, WIN - 1, WIN);
    win_chk("t4_we", 64, LOST);
    chk("t4_sticky_prio", ttc_lost_sticky, 1);
    chk("t4_lost_cnt", lost_cnt, 2);
    win(0, 3); win_chk("t4_idle", 0, LOST);
    chk("t4_sticky_clr", ttc_lost_sticky, 0);
    chk("t4_lost_once", lost_cnt, 2);

    // fast toggle saturates the counter and never qualifies
    for (int w = 0; w < 3; w++) begin
      run_window(0, 1, 0, 1'b1, -1, WIN);
      win_chk("t5_sat", 255, LOST);
    end

    // async reset in the middle of QUAL
    win(64, -1); win_chk("t6_w1", 64, QUAL);
    win(64, -1); win_chk("t6_w2", 64, QUAL);
    run_window(64, 15, 2, 1'b0, -1, 500);
    reset_n     = 1'b0;
    ttc_div_tgl = 1'b0;
    #1;
    chk("t6_rst_ready", ttc_ready, 0);
    chk("t6_rst_fcnt", ttc_freq_cnt, 0);
    chk("t6_rst_fv", freq_valid, 0);
    chk("t6_rst_state", state_dbg, LOST);
    step();
    step();
    reset_n = 1'b1;
    win(64, -1); win_chk("t6_r1", 64, QUAL);
    win(64, -1); win_chk("t6_r2", 64, QUAL);
    win(64, -1); win_chk("t6_r3", 64, QUAL);
    win(64, -1); win_chk("t6_r4", 64, READY);

    // mon_en=0 while READY: silent drop, fresh window on re-enable
    mon_en = 1'b0;
    step();
    chk("t6_dis_ready", ttc_ready, 0);
    chk("t6_dis_state", state_dbg, LOST);
    chk("t6_dis_lost", ttc_lost, 0);
    repeat (20) step();
    chk("t6_dis_fv", freq_valid, 0);
    chk("t6_dis_sticky", ttc_lost_sticky, 0);
    chk("t6_dis_lost_cnt", lost_cnt, 2);
    mon_en = 1'b1;
    win(64, -1); win_chk("t6_e1", 64, QUAL);
    win(64, -1); win_chk("t6_e2", 64, QUAL);
    win(64, -1); win_chk("t6_e3", 64, QUAL);
    win(64, -1); win_chk("t6_e4", 64, READY);
    chk("t6_final_lost_cnt", lost_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
